// File: rtl/stopwatch_ctrl.sv
// stopwatch_ctrl: debounced button sequencer for the stopwatch, with lap capture and display mux.
// Define LAP_COUNT_EN to add the saturating Lap_Count output.
module stopwatch_ctrl #(
    parameter int DEBOUNCE_CYC = 20
) (
    input  logic       Clock_1MSec,
    input  logic       Reset,
    input  logic       Btn_SS,
    input  logic       Btn_LR,
    input  logic       Btn_Mode,
    input  logic [3:0] Hours_S,
    input  logic [5:0] Mins_S,
    input  logic [5:0] Secs_S,
    input  logic [9:0] MSecs_S,
    output logic       Start_S,
    output logic       Stop_S,
    output logic       Reset_S,
    output logic       Control,
    output logic       Lap_Valid,
    output logic [3:0] Disp_Hours,
    output logic [5:0] Disp_Mins,
    output logic [5:0] Disp_Secs,
    output logic [9:0] Disp_MSecs,
`ifdef LAP_COUNT_EN
    output logic [3:0] Lap_Count,
`endif
    output logic [1:0] State
);
    typedef enum logic [1:0] {IDLE = 2'b00, RUN = 2'b01, PAUSE = 2'b10, LAP = 2'b11} state_t;
    state_t state;
    logic [2:0] raw, s0, s1, deb, deb_d, press;
    logic [7:0] cnt [3];
    logic [3:0] lap_hours;
    logic [5:0] lap_mins, lap_secs;
    logic [9:0] lap_msecs;
    logic ss, lr;
    assign raw = {Btn_Mode, Btn_LR, Btn_SS};
    // Bit 0 = start/stop, bit 1 = lap/reset, bit 2 = mode.
    always_ff @(posedge Clock_1MSec) begin
        if (Reset) begin
            s0    <= '0;
            s1    <= '0;
            deb   <= '0;
            deb_d <= '0;
            for (int i = 0; i < 3; i++) cnt[i] <= '0;
        end else begin
            s0    <= raw;
            s1    <= s0;
            deb_d <= deb;
            for (int i = 0; i < 3; i++) begin
                if (s1[i] == deb[i]) cnt[i] <= '0;
                else if (cnt[i] == 8'(DEBOUNCE_CYC - 1)) begin
                    deb[i] <= s1[i];
                    cnt[i] <= '0;
                end else cnt[i] <= cnt[i] + 8'd1;
            end
        end
    end
    assign press = deb & ~deb_d;
    assign ss    = press[0];
    assign lr    = press[1] & ~press[0];
    always_ff @(posedge Clock_1MSec) begin
        if (Reset) begin
            state     <= IDLE;
            Start_S   <= 1'b0;
            Stop_S    <= 1'b0;
            Reset_S   <= 1'b0;
            Control   <= 1'b0;
            Lap_Valid <= 1'b0;
            lap_hours <= '0;
            lap_mins  <= '0;
            lap_secs  <= '0;
            lap_msecs <= '0;
`ifdef LAP_COUNT_EN
            Lap_Count <= '0;
`endif
        end else begin
            Start_S <= 1'b0;
            Stop_S  <= 1'b0;
            Reset_S <= 1'b0;
            if (press[2]) Control <= ~Control;
            case (state)
                IDLE: if (ss) begin
                    Start_S <= 1'b1;
                    state   <= RUN;
                end
                RUN: if (ss) begin
                    Stop_S <= 1'b1;
                    state  <= PAUSE;
                end else if (lr) begin
                    lap_hours <= Hours_S;
                    lap_mins  <= Mins_S;
                    lap_secs  <= Secs_S;
                    lap_msecs <= MSecs_S;
                    Lap_Valid <= 1'b1;
                    state     <= LAP;
`ifdef LAP_COUNT_EN
                    if (Lap_Count != 4'd15) Lap_Count <= Lap_Count + 4'd1;
`endif
                end
                LAP: if (ss) begin
                    Stop_S    <= 1'b1;
                    Lap_Valid <= 1'b0;
                    state     <= PAUSE;
                end else if (lr) begin
                    Lap_Valid <= 1'b0;
                    state     <= RUN;
                end
                PAUSE: if (ss) begin
                    Start_S <= 1'b1;
                    state   <= RUN;
                end else if (lr) begin
                    Reset_S <= 1'b1;
                    state   <= IDLE;
`ifdef LAP_COUNT_EN
                    Lap_Count <= '0;
`endif
                end
            endcase
        end
    end
    assign State      = state;
    assign Disp_Hours = Lap_Valid ? lap_hours : Hours_S;
    assign Disp_Mins  = Lap_Valid ? lap_mins  : Mins_S;
    assign Disp_Secs  = Lap_Valid ? lap_secs  : Secs_S;
    assign Disp_MSecs = Lap_Valid ? lap_msecs : MSecs_S;
endmodule

// File: tb/tb_stopwatch_ctrl.sv
// tb_stopwatch_ctrl: directed and random button sequences against a table-driven stopwatch model.
module tb_stopwatch_ctrl;
    localparam int DEB = 20;
    logic clk = 1'b0;
    logic Reset, Btn_SS, Btn_LR, Btn_Mode;
    logic [3:0] Hours_S;
    logic [5:0] Mins_S, Secs_S;
    logic [9:0] MSecs_S;
    logic Start_S, Stop_S, Reset_S, Control, Lap_Valid;
    logic [3:0] Disp_Hours;
    logic [5:0] Disp_Mins, Disp_Secs;
    logic [9:0] Disp_MSecs;
    logic [1:0] State;
`ifdef LAP_COUNT_EN
    logic [3:0] Lap_Count;
`endif
    int n_err = 0;
    int n_checks = 0;
    int m_state, m_cnt;
    bit m_ctl, live_rand;
    logic [25:0] m_lap;
    // State encoding IDLE=0 RUN=1 PAUSE=2 LAP=3; next state on a start/stop or lap/reset press.
    int ns_ss [4] = '{1, 2, 1, 2};
    int ns_lr [4] = '{0, 3, 0, 1};

    always #5 clk = ~clk;

    stopwatch_ctrl #(.DEBOUNCE_CYC(DEB)) dut (
        .Clock_1MSec(clk), .Reset(Reset), .Btn_SS(Btn_SS), .Btn_LR(Btn_LR), .Btn_Mode(Btn_Mode),
        .Hours_S(Hours_S), .Mins_S(Mins_S), .Secs_S(Secs_S), .MSecs_S(MSecs_S),
        .Start_S(Start_S), .Stop_S(Stop_S), .Reset_S(Reset_S), .Control(Control), .Lap_Valid(Lap_Valid),
        .Disp_Hours(Disp_Hours), .Disp_Mins(Disp_Mins), .Disp_Secs(Disp_Secs), .Disp_MSecs(Disp_MSecs),
`ifdef LAP_COUNT_EN
        .Lap_Count(Lap_Count),
`endif
        .State(State)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_state = 0;
        m_cnt = 0;
        m_ctl = 1'b0;
        m_lap = '0;
    endtask

    task automatic apply(input bit ss, input bit lr, input bit md, output logic [2:0] p);
        p = 3'b000;
        if (md) m_ctl = ~m_ctl;
        if (ss) begin
            p = (m_state == 0 || m_state == 2) ? 3'b100 : 3'b010;
            m_state = ns_ss[m_state];
        end else if (lr) begin
            if (m_state == 2) begin
                p = 3'b001;
                m_cnt = 0;
            end
            if (m_state == 1) begin
                m_lap = {Hours_S, Mins_S, Secs_S, MSecs_S};
                if (m_cnt < 15) m_cnt++;
            end
            m_state = ns_lr[m_state];
        end
    endtask

    task automatic check_all(input logic [2:0] exp_p);
        chk("state", 32'(State), 32'(m_state));
        chk("pulses", 32'({Start_S, Stop_S, Reset_S}), 32'(exp_p));
        chk("control", 32'(Control), 32'(m_ctl));
        chk("lap_valid", 32'(Lap_Valid), 32'(m_state == 3));
        chk("disp", 32'({Disp_Hours, Disp_Mins, Disp_Secs, Disp_MSecs}),
            32'(m_state == 3 ? m_lap : {Hours_S, Mins_S, Secs_S, MSecs_S}));
`ifdef LAP_COUNT_EN
        chk("lap_count", 32'(Lap_Count), 32'(m_cnt));
`endif
    endtask

    // Raw press of the chosen buttons for `hold` cycles; the action lands DEB+3 cycles after the edge.
    task automatic push(input bit ss, input bit lr, input bit md, input int hold, input bit rst_rel);
        int ev = DEB + 3;
        int total = ((hold > ev) ? hold : ev) + DEB + 6;
        logic [2:0] p;
        @(negedge clk);
        Btn_SS = ss;
        Btn_LR = lr;
        Btn_Mode = md;
        if (rst_rel) Reset = 1'b0;
        for (int j = 1; j <= total; j++) begin
            @(negedge clk);
            if (j == hold) {Btn_SS, Btn_LR, Btn_Mode} = 3'b000;
            p = 3'b000;
            if (hold >= DEB && j == ev) apply(ss, lr, md, p);
            check_all(p);
            if (live_rand) begin
                Hours_S = 4'($urandom_range(0, 15));
                Mins_S  = 6'($urandom_range(0, 59));
                Secs_S  = 6'($urandom_range(0, 59));
                MSecs_S = 10'($urandom_range(0, 999));
            end
        end
    endtask

    initial begin
        Reset = 1'b1;
        {Btn_SS, Btn_LR, Btn_Mode} = 3'b000;
        {Hours_S, Mins_S, Secs_S, MSecs_S} = '0;
        live_rand = 1'b1;
        model_reset();
        repeat (3) @(negedge clk);
        check_all(3'b000);
        push(1, 0, 0, 10, 1);
        push(1, 0, 0, 30, 0);
        push(1, 0, 0, DEB - 1, 0);
        push(1, 0, 0, DEB, 0);
        push(0, 1, 0, DEB, 0);
        push(1, 0, 0, DEB, 0);
        live_rand = 1'b0;
        {Hours_S, Mins_S, Secs_S, MSecs_S} = {4'd0, 6'd1, 6'd2, 10'd345};
        push(0, 1, 0, 25, 0);
        chk("lap_frozen", 32'({Disp_Hours, Disp_Mins, Disp_Secs, Disp_MSecs}), 32'({4'd0, 6'd1, 6'd2, 10'd345}));
        live_rand = 1'b1;
        push(0, 0, 0, 0, 0);
        chk("lap_held", 32'({Disp_Hours, Disp_Mins, Disp_Secs, Disp_MSecs}), 32'({4'd0, 6'd1, 6'd2, 10'd345}));
        push(0, 1, 0, 25, 0);
        chk("lap_exit", 32'(State), 32'd1);
`ifdef LAP_COUNT_EN
        chk("lap_count_1", 32'(Lap_Count), 32'd1);
`endif
        for (int k = 0; k < 15; k++) begin
            push(0, 1, 0, DEB, 0);
            push(0, 1, 0, DEB, 0);
        end
`ifdef LAP_COUNT_EN
        chk("lap_count_sat", 32'(Lap_Count), 32'd15);
`endif
        push(1, 0, 0, DEB, 0);
        push(0, 1, 0, DEB, 0);
        chk("cleared_idle", 32'(State), 32'd0);
`ifdef LAP_COUNT_EN
        chk("lap_count_clr", 32'(Lap_Count), 32'd0);
`endif
        push(1, 0, 0, DEB, 0);
        push(0, 1, 0, DEB, 0);
        push(0, 1, 0, DEB, 0);
        push(1, 1, 0, DEB, 0);
        chk("both_pause", 32'({State, Lap_Valid}), 32'({2'b10, 1'b0}));
        push(1, 0, 0, DEB, 0);
        push(0, 0, 1, DEB, 0);
        chk("mode_run", 32'({State, Control}), 32'({2'b01, 1'b1}));
        @(negedge clk);
        Btn_SS = 1'b1;
        repeat (10) @(negedge clk);
        Reset = 1'b1;
        Btn_SS = 1'b0;
        model_reset();
        repeat (2) @(negedge clk);
        chk("rst_zero", 32'({Start_S, Stop_S, Reset_S, Control, Lap_Valid, State}), 32'd0);
        push(0, 0, 0, 0, 1);
        @(negedge clk);
        Btn_SS = 1'b1;
        Reset = 1'b1;
        model_reset();
        repeat (3) @(negedge clk);
        check_all(3'b000);
        push(1, 0, 0, 30, 1);
        chk("held_start", 32'(State), 32'd1);
        for (int k = 0; k < 40; k++)
            push(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                 $urandom_range(1, DEB + 8), 0);
        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end
endmodule
